// File: rtl/axil2iob_pkg.sv
// axil2iob shared types: FSM states, response codes
// and the write-dispatch helper.
package axil2iob_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_W,
    WAIT_AW,
    WRITE,
    W_RESP,
    READ,
    R_RESP
  } state_t;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  // An all-zero strobe would look like a read on the native bus.
  function automatic state_t write_next(input logic zero_strb);
    return zero_strb ? W_RESP : WRITE;
  endfunction

endpackage

// File: rtl/axil2iob.sv
// AXI4-Lite slave to IOb native master bridge.
// One transaction in flight; writes win over reads.
module axil2iob
  import axil2iob_pkg::*;
#(
  parameter int AXIL_ADDR_W = 32,
  parameter int AXIL_DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,

  input  logic [AXIL_ADDR_W-1:0]   s_axil_awaddr,
  input  logic [2:0]               s_axil_awprot,
  input  logic                     s_axil_awvalid,
  output logic                     s_axil_awready,

  input  logic [AXIL_DATA_W-1:0]   s_axil_wdata,
  input  logic [AXIL_DATA_W/8-1:0] s_axil_wstrb,
  input  logic                     s_axil_wvalid,
  output logic                     s_axil_wready,

  output logic [1:0]               s_axil_bresp,
  output logic                     s_axil_bvalid,
  input  logic                     s_axil_bready,

  input  logic [AXIL_ADDR_W-1:0]   s_axil_araddr,
  input  logic [2:0]               s_axil_arprot,
  input  logic                     s_axil_arvalid,
  output logic                     s_axil_arready,

  output logic [AXIL_DATA_W-1:0]   s_axil_rdata,
  output logic [1:0]               s_axil_rresp,
  output logic                     s_axil_rvalid,
  input  logic                     s_axil_rready,

  output logic                     valid,
  output logic [AXIL_ADDR_W-1:0]   addr,
  output logic [AXIL_DATA_W-1:0]   wdata,
  output logic [AXIL_DATA_W/8-1:0] wstrb,
  input  logic [AXIL_DATA_W-1:0]   rdata,
  input  logic                     ready
);

  localparam int SW = AXIL_DATA_W / 8;

  state_t state_q;
  state_t state_d;

  logic [AXIL_ADDR_W-1:0] addr_q;
  logic [AXIL_DATA_W-1:0] wdata_q;
  logic [SW-1:0]          wstrb_q;
  logic [AXIL_DATA_W-1:0] rdata_q;

  logic aw_hs;
  logic w_hs;
  logic ar_hs;
  logic rd_done;
  logic unused_prot;

  assign unused_prot = ^{s_axil_awprot, s_axil_arprot};

  // Readies are masked during reset so every output reads 0.
  assign s_axil_awready = !rst &&
    (state_q == IDLE || state_q == WAIT_AW);
  assign s_axil_wready  = !rst &&
    (state_q == IDLE || state_q == WAIT_W);
  assign s_axil_arready = !rst && state_q == IDLE &&
    !s_axil_awvalid && !s_axil_wvalid;

  assign aw_hs   = s_axil_awvalid && s_axil_awready;
  assign w_hs    = s_axil_wvalid && s_axil_wready;
  assign ar_hs   = s_axil_arvalid && s_axil_arready;
  assign rd_done = state_q == READ && ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (aw_hs && w_hs)
          state_d = write_next(s_axil_wstrb == '0);
        else if (aw_hs)
          state_d = WAIT_W;
        else if (w_hs)
          state_d = WAIT_AW;
        else if (ar_hs)
          state_d = READ;
      end
      WAIT_W:
        if (w_hs)
          state_d = write_next(s_axil_wstrb == '0);
      WAIT_AW:
        if (aw_hs)
          state_d = write_next(wstrb_q == '0);
      WRITE:
        if (ready) state_d = W_RESP;
      W_RESP:
        if (s_axil_bready) state_d = IDLE;
      READ:
        if (ready) state_d = R_RESP;
      R_RESP:
        if (s_axil_rready) state_d = IDLE;
      default:
        state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (aw_hs)
        addr_q <= s_axil_awaddr;
      else if (ar_hs)
        addr_q <= s_axil_araddr;
      if (w_hs) begin
        wdata_q <= s_axil_wdata;
        wstrb_q <= s_axil_wstrb;
      end
      if (rd_done)
        rdata_q <= rdata;
    end
  end

  assign valid = state_q == WRITE || state_q == READ;
  assign addr  = addr_q;
  assign wdata = wdata_q;
  assign wstrb = state_q == READ ? '0 : wstrb_q;

  assign s_axil_bvalid = state_q == W_RESP;
  assign s_axil_bresp  = RESP_OKAY;
  assign s_axil_rvalid = state_q == R_RESP;
  assign s_axil_rdata  = rdata_q;
  assign s_axil_rresp  = RESP_OKAY;

endmodule

// File: tb/tb_axil2iob.sv
// Self-checking bench for axil2iob: directed steps plus
// random traffic against a byte-level memory model.
module tb_axil2iob;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s_axil_awaddr;
  logic [2:0]  s_axil_awprot;
  logic        s_axil_awvalid;
  logic        s_axil_awready;
  logic [31:0] s_axil_wdata;
  logic [3:0]  s_axil_wstrb;
  logic        s_axil_wvalid;
  logic        s_axil_wready;
  logic [1:0]  s_axil_bresp;
  logic        s_axil_bvalid;
  logic        s_axil_bready;
  logic [31:0] s_axil_araddr;
  logic [2:0]  s_axil_arprot;
  logic        s_axil_arvalid;
  logic        s_axil_arready;
  logic [31:0] s_axil_rdata;
  logic [1:0]  s_axil_rresp;
  logic        s_axil_rvalid;
  logic        s_axil_rready;
  logic        valid;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [31:0] rdata;
  logic        ready;

  axil2iob #(.AXIL_ADDR_W(32), .AXIL_DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .s_axil_awaddr(s_axil_awaddr), .s_axil_awprot(s_axil_awprot),
    .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
    .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb),
    .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(s_axil_wready),
    .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid),
    .s_axil_bready(s_axil_bready),
    .s_axil_araddr(s_axil_araddr), .s_axil_arprot(s_axil_arprot),
    .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
    .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
    .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
    .valid(valid), .addr(addr), .wdata(wdata), .wstrb(wstrb),
    .rdata(rdata), .ready(ready)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail = 0;

  // rmem: what the AXI master expects; pmem: the native peripheral.
  logic [31:0] rmem [logic [31:0]];
  logic [31:0] pmem [logic [31:0]];

  function automatic logic [31:0] merge(input logic [31:0] old,
                                        input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] rm(input logic [31:0] a);
    return rmem.exists(a) ? rmem[a] : 32'h0;
  endfunction

  function automatic logic [31:0] pm(input logic [31:0] a);
    return pmem.exists(a) ? pmem[a] : 32'h0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs,
                      input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] s, input int aw_dly,
                    input int w_dly, input int rdy_dly,
                    input int b_dly, input bit ar_hold);
    bit aw_done = 0;
    bit w_done = 0;
    bit b_done = 0;
    bit aw_prev;
    bit w_prev;
    int c = 0, nv = 0, nb = 0, nw = 0, ar_early = 0;
    int hs = -1, bc = -1, vc = -1;
    bit nat;
    nat = (s != 4'h0);
    while (!b_done && c < 100) begin
      @(negedge clk);
      s_axil_awvalid = !aw_done && c >= aw_dly;
      s_axil_awaddr  = s_axil_awvalid ? a : $urandom;
      s_axil_awprot  = 3'($urandom);
      s_axil_wvalid  = !w_done && c >= w_dly;
      s_axil_wdata   = s_axil_wvalid ? d : $urandom;
      s_axil_wstrb   = s_axil_wvalid ? s : 4'($urandom);
      s_axil_arvalid = ar_hold;
      s_axil_bready  = s_axil_bvalid && nb >= b_dly;
      s_axil_rready  = 1'b0;
      ready = valid && nv == rdy_dly;
      rdata = $urandom;
      aw_prev = aw_done;
      w_prev = w_done;
      #1;
      if (s_axil_awvalid && s_axil_awready) aw_done = 1;
      if (s_axil_wvalid && s_axil_wready) w_done = 1;
      if (aw_done && w_done && hs < 0) hs = c;
      if (aw_prev && !w_prev) begin
        chk1("wait_w_awready", s_axil_awready, 1'b0);
        chk1("wait_w_wready", s_axil_wready, 1'b1);
      end
      if (w_prev && !aw_prev) begin
        chk1("wait_aw_awready", s_axil_awready, 1'b1);
        chk1("wait_aw_wready", s_axil_wready, 1'b0);
      end
      if (ar_hold && s_axil_arready) ar_early++;
      if (valid) begin
        if (vc < 0) vc = c;
        chk("wr_addr", addr, a);
        chk("wr_wdata", wdata, d);
        chk("wr_wstrb", {28'h0, wstrb}, {28'h0, s});
        if (ready) begin
          nw++;
          pmem[addr] = merge(pm(addr), wdata, wstrb);
        end
        nv++;
      end
      if (s_axil_bvalid) begin
        chk("bresp", {30'h0, s_axil_bresp}, 32'h0);
        if (bc < 0) bc = c;
        if (s_axil_bready) b_done = 1;
        nb++;
      end
      c++;
    end
    chk1("b_done", b_done, 1'b1);
    chk("native_writes", nw, nat ? 1 : 0);
    chk("native_valid_cycles", nv, nat ? rdy_dly + 1 : 0);
    if (nat) chk("valid_lat", vc - hs, 1);
    chk("b_lat", bc - hs, nat ? rdy_dly + 2 : 1);
    chk("b_cycles", nb, b_dly + 1);
    chk("ar_early", ar_early, 0);
    rmem[a] = merge(rm(a), d, s);
  endtask

  task automatic rd(input logic [31:0] a, input int ar_dly,
                    input int rdy_dly, input int r_dly);
    bit ar_done = 0;
    bit r_done = 0;
    int c = 0, nv = 0, nr = 0, hs = -1, rc = -1;
    logic [31:0] exp;
    exp = rm(a);
    while (!r_done && c < 100) begin
      @(negedge clk);
      s_axil_awvalid = 1'b0;
      s_axil_wvalid  = 1'b0;
      s_axil_bready  = 1'b0;
      s_axil_arvalid = !ar_done && c >= ar_dly;
      s_axil_araddr  = s_axil_arvalid ? a : $urandom;
      s_axil_arprot  = 3'($urandom);
      ready = valid && nv == rdy_dly;
      rdata = ready ? pm(addr) : $urandom;
      s_axil_rready = s_axil_rvalid && nr >= r_dly;
      #1;
      if (s_axil_arvalid && s_axil_arready) begin
        ar_done = 1;
        hs = c;
      end
      if (valid) begin
        chk("rd_addr", addr, a);
        chk("rd_wstrb", {28'h0, wstrb}, 32'h0);
        nv++;
      end
      if (s_axil_rvalid) begin
        chk("rdata", s_axil_rdata, exp);
        chk("rresp", {30'h0, s_axil_rresp}, 32'h0);
        if (rc < 0) rc = c;
        if (s_axil_rready) r_done = 1;
        nr++;
      end
      c++;
    end
    chk1("r_done", r_done, 1'b1);
    chk("ar_lat", hs, ar_dly);
    chk("rd_valid_cycles", nv, rdy_dly + 1);
    chk("r_lat", rc - hs, rdy_dly + 2);
    chk("r_cycles", nr, r_dly + 1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk1({tag, "_valid"}, valid, 1'b0);
    chk({tag, "_addr"}, addr, 32'h0);
    chk({tag, "_wdata"}, wdata, 32'h0);
    chk({tag, "_wstrb"}, {28'h0, wstrb}, 32'h0);
    chk1({tag, "_bvalid"}, s_axil_bvalid, 1'b0);
    chk1({tag, "_rvalid"}, s_axil_rvalid, 1'b0);
    chk({tag, "_rdata"}, s_axil_rdata, 32'h0);
    chk({tag, "_resp"}, {28'h0, s_axil_bresp, s_axil_rresp}, 32'h0);
  endtask

  initial begin
    int nrv;
    rst = 1'b1;
    s_axil_awaddr = '0; s_axil_awprot = '0; s_axil_awvalid = 1'b0;
    s_axil_wdata = '0; s_axil_wstrb = '0; s_axil_wvalid = 1'b0;
    s_axil_bready = 1'b0;
    s_axil_araddr = '0; s_axil_arprot = '0; s_axil_arvalid = 1'b0;
    s_axil_rready = 1'b0;
    rdata = '0; ready = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    chk_all_zero("reset");
    chk("reset_readies",
        {29'h0, s_axil_awready, s_axil_wready, s_axil_arready}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("idle_readies",
        {29'h0, s_axil_awready, s_axil_wready, s_axil_arready}, 32'h7);

    // Aligned write, ready one cycle after valid would be rdy_dly=1;
    // the plan's "ready at N+1" is rdy_dly=0.
    wr(32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0);
    rd(32'h10, 0, 0, 0);

    // Split write: W three cycles ahead of AW, then AW ahead of W.
    wr(32'h20, 32'hCAFEF00D, 4'hF, 3, 0, 1, 0, 0);
    wr(32'h24, 32'h01234567, 4'h5, 0, 2, 2, 1, 0);
    rd(32'h20, 1, 0, 0);
    rd(32'h24, 0, 1, 2);

    // Read with late ready and R backpressure.
    pmem[32'h30] = 32'h12345678;
    rmem[32'h30] = 32'h12345678;
    rd(32'h30, 0, 4, 5);

    // AW, W and AR together: write first, AR only once back in IDLE.
    s_axil_araddr = 32'h10;
    wr(32'h14, 32'hA5A5A5A5, 4'hF, 0, 0, 1, 2, 1);
    rd(32'h10, 0, 0, 0);
    rd(32'h14, 0, 0, 0);

    // Zero-strobe writes: aligned, AW first, W first.
    wr(32'h10, 32'hFFFFFFFF, 4'h0, 0, 0, 0, 1, 0);
    wr(32'h10, 32'h11111111, 4'h0, 0, 2, 0, 0, 0);
    wr(32'h10, 32'h22222222, 4'h0, 2, 0, 0, 0, 0);
    rd(32'h10, 0, 0, 0);

    // Reset while the native read is outstanding, then a late ready.
    @(negedge clk);
    s_axil_arvalid = 1'b1;
    s_axil_araddr = 32'h50;
    #1;
    chk1("mid_arready", s_axil_arready, 1'b1);
    @(negedge clk);
    s_axil_arvalid = 1'b0;
    #1;
    chk1("mid_valid", valid, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_readies",
        {29'h0, s_axil_awready, s_axil_wready, s_axil_arready}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    ready = 1'b1;
    rdata = 32'hBAD0BAD0;
    #1;
    chk_all_zero("after_rst");
    chk1("after_rst_arready", s_axil_arready, 1'b1);
    nrv = 0;
    repeat (4) begin
      @(negedge clk);
      ready = 1'b1;
      #1;
      if (s_axil_rvalid || s_axil_bvalid || valid) nrv++;
    end
    chk("late_ready_ignored", nrv, 0);
    @(negedge clk);
    ready = 1'b0;

    // Random traffic over a small address window.
    for (int i = 0; i < 60; i++) begin
      logic [31:0] ra;
      ra = 32'($urandom_range(0, 15)) << 2;
      if ($urandom_range(0, 1) == 1)
        wr(ra, $urandom, 4'($urandom), $urandom_range(0, 3),
           $urandom_range(0, 3), $urandom_range(0, 3),
           $urandom_range(0, 2), 1'b0);
      else
        rd(ra, $urandom_range(0, 2), $urandom_range(0, 3),
           $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
